// File: rtl/pal_cfg_loader.sv
// Configuration sequencer for the PAL array: accepts parallel bitstream words
// over valid/ready and shifts them LSB first into the serial CFG chain.
module pal_cfg_loader #(
   parameter int N = 4,
   parameter int M = 3,
   parameter int P = 3,
   parameter int W = 8
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         START,
   input  logic [W-1:0] WORD_DATA,
   input  logic         WORD_VALID,
   output logic         WORD_READY,
   output logic         PAL_CFG,
   output logic         PAL_CLK_EN,
   output logic         BUSY,
   output logic         DONE
);

   localparam int L  = 2*N*P + P*M;
   localparam int RW = $clog2(L+1);
   localparam int CW = $clog2(W+1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

   state_t        state, state_nx;
   logic [W-1:0]  sreg, sreg_nx;
   logic [CW-1:0] bits, bits_nx;
   logic [RW-1:0] rem, rem_nx;
   logic [CW-1:0] take;
   logic          cfg_nx, en_nx;

   // bits counts the word bits still to present after the one on PAL_CFG
   always_comb take = (32'(rem) >= 32'(W)) ? CW'(W) : CW'(rem);

   always_comb begin
      state_nx = state;
      sreg_nx  = sreg;
      bits_nx  = bits;
      rem_nx   = rem;
      cfg_nx   = 1'b0;
      en_nx    = 1'b0;
      case (state)
         S_IDLE, S_DONE: begin
            if (START) begin
               state_nx = S_LOAD;
               rem_nx   = RW'(L);
            end
         end
         S_LOAD: begin
            if (WORD_VALID) begin
               state_nx = S_SHIFT;
               cfg_nx   = WORD_DATA[0];
               en_nx    = 1'b1;
               sreg_nx  = WORD_DATA >> 1;
               bits_nx  = take - CW'(1);
               rem_nx   = rem - RW'(1);
            end
         end
         S_SHIFT: begin
            if (bits != '0) begin
               cfg_nx  = sreg[0];
               en_nx   = 1'b1;
               sreg_nx = sreg >> 1;
               bits_nx = bits - CW'(1);
               rem_nx  = rem - RW'(1);
            end else begin
               state_nx = (rem == '0) ? S_DONE : S_LOAD;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= S_IDLE;
         sreg       <= '0;
         bits       <= '0;
         rem        <= '0;
         WORD_READY <= 1'b0;
         PAL_CFG    <= 1'b0;
         PAL_CLK_EN <= 1'b0;
         BUSY       <= 1'b0;
         DONE       <= 1'b0;
      end else begin
         state      <= state_nx;
         sreg       <= sreg_nx;
         bits       <= bits_nx;
         rem        <= rem_nx;
         WORD_READY <= (state_nx == S_LOAD);
         PAL_CFG    <= cfg_nx;
         PAL_CLK_EN <= en_nx;
         BUSY       <= (state_nx == S_LOAD) || (state_nx == S_SHIFT);
         DONE       <= (state_nx == S_DONE);
      end
   end

endmodule

// File: tb/tb_pal_cfg_loader.sv
// Directed bench for pal_cfg_loader: default build (L=33) and a small build
// (N=2,M=2,P=2,W=4, L=12) sharing one stimulus driver.
module tb_pal_cfg_loader;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       valid = 1'b0;
   logic [7:0] data = '0;
   bit         sel = 1'b0;
   int         total = 0;
   int         bad = 0;
   logic [7:0] words [5];

   logic a_ready, a_cfg, a_en, a_busy, a_done;
   logic b_ready, b_cfg, b_en, b_busy, b_done;
   logic o_ready, o_cfg, o_en, o_busy, o_done;

   always #5 clk = ~clk;

   pal_cfg_loader dut_a (
      .CLK(clk), .RST(rst), .START(start && !sel), .WORD_DATA(data),
      .WORD_VALID(valid && !sel), .WORD_READY(a_ready), .PAL_CFG(a_cfg),
      .PAL_CLK_EN(a_en), .BUSY(a_busy), .DONE(a_done)
   );

   pal_cfg_loader #(.N(2), .M(2), .P(2), .W(4)) dut_b (
      .CLK(clk), .RST(rst), .START(start && sel), .WORD_DATA(data[3:0]),
      .WORD_VALID(valid && sel), .WORD_READY(b_ready), .PAL_CFG(b_cfg),
      .PAL_CLK_EN(b_en), .BUSY(b_busy), .DONE(b_done)
   );

   assign o_ready = sel ? b_ready : a_ready;
   assign o_cfg   = sel ? b_cfg   : a_cfg;
   assign o_en    = sel ? b_en    : a_en;
   assign o_busy  = sel ? b_busy  : a_busy;
   assign o_done  = sel ? b_done  : a_done;

   task automatic chk(input string tag, input int act, input int exp_v);
      total++;
      if (act != exp_v) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, act, exp_v);
      end
   endtask

   // One load: optional stall before gap_word, START pulse at cycle start_k,
   // async reset at cycle rst_k (ends the load early). Cycle k = after edge t+k.
   task automatic run_load(input int gap_word, input int gap_len, input int start_k,
                           input int rst_k, input int exp_lat, input string tg);
      int idx, gapcnt, gap_en, gap_nbusy, npulse, nbad, lat, wl, ll;
      logic [7:0] w;
      wl = sel ? 4 : 8;
      ll = sel ? 12 : 33;
      idx = 0; gapcnt = 0; gap_en = 0; gap_nbusy = 0; npulse = 0; nbad = 0; lat = -1;
      @(negedge clk);
      start = 1'b1;
      valid = 1'b0;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (k == 0) begin
            chk({tg, ".ready_after_start"}, int'(o_ready), 1);
            chk({tg, ".done_clear"}, int'(o_done), 0);
         end
         if (o_done) begin
            lat = k;
            break;
         end
         if (o_en) begin
            if (npulse < ll) begin
               w = words[npulse / wl];
               if (o_cfg !== w[npulse % wl]) nbad++;
            end
            npulse++;
         end
         start = (k == start_k);
         if (k == rst_k) begin
            chk({tg, ".mid_shift"}, int'(o_en), 1);
            #2 rst = 1'b1;
            #1 chk({tg, ".rst_outs"}, int'({o_ready, o_cfg, o_en, o_busy, o_done}), 0);
            #1 rst = 1'b0;
            start = 1'b0;
            valid = 1'b0;
            return;
         end
         valid = 1'b1;
         data  = words[idx < 5 ? idx : 4];
         if (idx == gap_word && o_ready && gapcnt < gap_len) begin
            valid = 1'b0;
            gapcnt++;
            if (o_en) gap_en++;
            if (!o_busy) gap_nbusy++;
         end
         if (valid && o_ready) idx++;
         @(posedge clk);
      end
      valid = 1'b0;
      start = 1'b0;
      chk({tg, ".done_latency"}, lat, exp_lat);
      chk({tg, ".pulses"}, npulse, ll);
      chk({tg, ".bit_errors"}, nbad, 0);
      if (gap_len > 0) begin
         chk({tg, ".gap_cycles"}, gapcnt, gap_len);
         chk({tg, ".gap_pulses"}, gap_en, 0);
         chk({tg, ".gap_notbusy"}, gap_nbusy, 0);
      end
   endtask

   initial begin
      words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF;
      words[3] = 8'h00; words[4] = 8'h01;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_a", int'({a_ready, a_cfg, a_en, a_busy, a_done}), 0);
      chk("reset_b", int'({b_ready, b_cfg, b_en, b_busy, b_done}), 0);
      rst = 1'b0;

      run_load(-1, 0, -1, -1, 38, "basic");

      // DONE holds; stray WORD_VALID is not accepted
      valid = 1'b1;
      repeat (3) @(negedge clk);
      chk("hold_done", int'(o_done), 1);
      chk("hold_ready", int'(o_ready), 0);
      chk("hold_en", int'(o_en), 0);
      valid = 1'b0;

      run_load(3, 10, -1, -1, 48, "stall");
      run_load(-1, 0, 22, -1, 38, "start_ignored");
      run_load(-1, 0, -1, 12, 0, "reset_mid");
      run_load(-1, 0, -1, -1, 38, "after_reset");

      for (int i = 0; i < 5; i++) words[i] = 8'hFF;
      run_load(-1, 0, -1, -1, 38, "reload_ones");

      sel = 1'b1;
      words[0] = 8'h09; words[1] = 8'h06; words[2] = 8'h0C;
      run_load(-1, 0, -1, -1, 15, "small");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got 1 want 0");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/pal_cfg_loader.md
# pal_cfg_loader

Configuration sequencer for the PAL array. Accepts the configuration bitstream as parallel words over a valid/ready port and shifts it, LSB first, into the PAL's serial CFG chain. It drives a per-bit clock enable that gates the PAL clock, and flags DONE once exactly the chain length has been shifted. It sits between the host/ROM bitstream source and the PAL instance's CFG/CLK inputs.

## Interface

- N, 4, number of PAL input variables
- M, 3, number of PAL outputs
- P, 3, number of product-term (intermediate) stages
- W, 8, bitstream word width
- Derived L = 2*N*P + P*M (chain length; 33 at defaults); NW = ceil(L/W) (5 at defaults)

- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous reset, active-high
- START  in  1  request a (re)load; sampled only in IDLE or DONE
- WORD_DATA  in  W  bitstream word; bit 0 is shifted first
- WORD_VALID  in  1  WORD_DATA valid
- WORD_READY  out  1  loader accepts a word this cycle
- PAL_CFG  out  1  serial config bit to the PAL CFG input
- PAL_CLK_EN  out  1  PAL clock enable; one pulse per shifted bit
- BUSY  out  1  load in progress (LOAD or SHIFT)
- DONE  out  1  level; chain fully loaded, PAL config valid

## Operation

- States: IDLE, LOAD, SHIFT, DONE.
- IDLE: all outputs 0. START=1 -> LOAD.
- LOAD: WORD_READY=1, BUSY=1, PAL_CLK_EN=0. On WORD_VALID&&WORD_READY, latch WORD_DATA into the shift register, set word bit count n = min(W, remaining) -> SHIFT.
- SHIFT: each cycle PAL_CFG = shift_reg[0] and PAL_CLK_EN=1; shift right; decrement the remaining and n counters. After the n-th bit: if remaining==0 -> DONE, else -> LOAD.
- DONE: DONE=1, PAL_CLK_EN=0, PAL_CFG=0. START=1 -> LOAD (DONE clears the same edge). Otherwise hold indefinitely.
- Remaining counter: width clog2(L+1), loaded with L on START. It never underflows.
- Last word: only L - (NW-1)*W low bits are shifted; upper bits are discarded.
- START in LOAD or SHIFT is ignored.
- WORD_VALID outside LOAD is ignored; no word is consumed.
- Total PAL_CLK_EN pulses per load is exactly L, and none occur outside SHIFT.

## Timing

- Reset (async, any state): state=IDLE. WORD_READY, PAL_CFG, PAL_CLK_EN, BUSY and DONE are all 0. Counters and the shift register are cleared.
- Reset mid-load leaves PAL contents undefined. DONE stays 0 until a full reload completes.
- All outputs are registered and change only after the CLK rising edge. PAL_CFG and PAL_CLK_EN change together, so the PAL samples a stable bit on the following edge.
- START sampled at edge t -> WORD_READY=1 after edge t.
- Word accepted at edge j -> bit 0 on PAL_CFG with PAL_CLK_EN=1 after edge j. Bits k = 0..n-1 occupy the cycles after edges j..j+n-1.
- Each word costs 1 LOAD cycle + n SHIFT cycles, so there is one bubble cycle between words.
- With WORD_VALID held high, DONE rises after edge t + NW + L (t+38 at defaults).
- WORD_VALID low stalls LOAD indefinitely. PAL_CLK_EN stays 0 and BUSY stays 1 during the stall.

## Test plan

- Default params, WORD_VALID always 1, words 0xA5,0x3C,0xFF,0x00,0x01.
  - PAL_CFG sequence is 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1×8, 0×8, 1.
  - Exactly 33 PAL_CLK_EN pulses.
  - DONE rises at START edge +38.
  - Upper 7 bits of 0x01 are never shifted.
- WORD_VALID deasserted for 10 cycles before word 3:
  - WORD_READY held 1, no PAL_CLK_EN pulses during the gap.
  - Same bit sequence as above; DONE delayed by exactly 10 cycles.
- START pulsed during SHIFT of word 2: ignored. Pulse count stays 33, sequence unchanged.
- RST asserted asynchronously mid-SHIFT:
  - All outputs 0 immediately, state IDLE.
  - A subsequent START performs a full 33-bit load from word 0.
- In DONE, START with new words 0xFF×5:
  - DONE drops at the START edge.
  - 33 ones are shifted; DONE re-asserts 38 cycles later.
- N=2, M=2, P=2, W=4 (L=12, NW=3, exact multiple):
  - Three words, 12 pulses, no discarded bits.
  - DONE at START edge +15.
